// File: rtl/kbt_pkg.sv
// kbt_pkg: shared constants, state encoding and helpers for the keyboard
// text controller (kb_text_ctrl and its key FIFO).
package kbt_pkg;

    // ASCII codes the controller interprets
    localparam logic [7:0] SPACE     = 8'h20;
    localparam logic [7:0] BS        = 8'h08;
    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    // Default screen geometry
    localparam int unsigned DEF_COLS = 80;
    localparam int unsigned DEF_ROWS = 30;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CLEAR
    } kbt_state_e;

    function automatic logic is_print(input logic [7:0] c);
        return (c >= PRINT_MIN) && (c <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/kbt_fifo.sv
// kbt_fifo: synchronous FIFO for buffered key codes.
//   clk, reset (async, active-low)
//   flush       : empties the FIFO (takes priority over push/pop)
//   push, din   : write when not full (a push while full is ignored)
//   pop         : advance the read side when not empty
//   dout        : current head entry
//   full, empty : status flags
//   level       : number of stored entries
module kbt_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/kb_text_ctrl.sv
// kb_text_ctrl: sequences character RAM writes from the keyboard decoder,
// tracks the text cursor, interprets BS/CR and runs full-screen clears.
// The renderer owns the single RAM port whenever vga_rd_req is high.
//   clk, reset (async, active-low)
//   key_valid/key_char   : decoded key strobe and ASCII code
//   clear_req            : request a full-screen clear sweep
//   vga_rd_req/addr      : renderer read request (always wins the port)
//   ram_addr/we/wdata    : shared RAM port
//   cursor_col/row       : current cursor position
//   busy                 : clear sweep in progress
//   ovf                  : sticky, a key was dropped on a full FIFO
module kb_text_ctrl
    import kbt_pkg::*;
#(
    parameter int unsigned COLS       = DEF_COLS,
    parameter int unsigned ROWS       = DEF_ROWS,
    parameter int unsigned AW         = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          key_valid,
    input  logic [7:0]    key_char,
    input  logic          clear_req,
    input  logic          vga_rd_req,
    input  logic [AW-1:0] vga_rd_addr,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    output logic [6:0]    cursor_col,
    output logic [4:0]    cursor_row,
    output logic          busy,
    output logic          ovf
);

    localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(COLS*ROWS - 1);
    localparam logic [AW-1:0] COLS_A    = AW'(COLS);
    localparam logic [6:0]    LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]    LAST_ROW  = 5'(ROWS - 1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);

    kbt_state_e    state, state_nx;
    logic [6:0]    col, col_nx;
    logic [4:0]    row, row_nx;
    logic [AW-1:0] row_base, base_nx;   // row*COLS, kept in step with row
    logic [AW-1:0] sweep, sweep_nx;

    logic          fifo_push, fifo_pop, fifo_flush;
    logic          fifo_full, fifo_empty;
    logic [7:0]    head;
    logic [LW-1:0] fifo_level;

    logic          wr_pend;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [4:0]    row_inc;
    logic [AW-1:0] base_inc;

    // clear_req discards a key arriving in the same cycle
    assign fifo_push = key_valid && !clear_req;

    kbt_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (key_char),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign row_inc  = (row == LAST_ROW) ? '0 : row + 1'b1;
    assign base_inc = (row == LAST_ROW) ? '0 : row_base + COLS_A;

    always_comb begin
        state_nx   = state;
        col_nx     = col;
        row_nx     = row;
        base_nx    = row_base;
        sweep_nx   = sweep;
        wr_pend    = 1'b0;
        wr_addr    = '0;
        wr_data    = 8'h00;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                if (fifo_empty) begin
                    state_nx = ST_IDLE;
                end else if (is_print(head)) begin
                    wr_pend = 1'b1;
                    wr_addr = row_base + AW'(col);
                    wr_data = head;
                    if (!vga_rd_req) begin
                        fifo_pop = 1'b1;
                        if (col == LAST_COL) begin
                            col_nx  = '0;
                            row_nx  = row_inc;
                            base_nx = base_inc;
                        end else begin
                            col_nx = col + 1'b1;
                        end
                    end
                end else if (head == BS) begin
                    wr_pend = 1'b1;
                    wr_data = SPACE;
                    // row_base-1 is the last column of the previous row
                    if (col != '0) begin
                        wr_addr = row_base + AW'(col) - 1'b1;
                    end else if (row != '0) begin
                        wr_addr = row_base - 1'b1;
                    end
                    if (!vga_rd_req) begin
                        fifo_pop = 1'b1;
                        if (col != '0) begin
                            col_nx = col - 1'b1;
                        end else if (row != '0) begin
                            col_nx  = LAST_COL;
                            row_nx  = row - 1'b1;
                            base_nx = row_base - COLS_A;
                        end
                    end
                end else if (head == CR) begin
                    fifo_pop = 1'b1;
                    col_nx   = '0;
                    row_nx   = row_inc;
                    base_nx  = base_inc;
                end else begin
                    fifo_pop = 1'b1;
                end
                // stay in WRITE if another entry remains after this pop
                if (fifo_pop) begin
                    state_nx = ((fifo_level > LVL_ONE) || (fifo_push && !fifo_full))
                               ? ST_WRITE : ST_IDLE;
                end
            end
            ST_CLEAR: begin
                wr_pend = 1'b1;
                wr_addr = sweep;
                wr_data = SPACE;
                if (!vga_rd_req) begin
                    if (sweep == LAST_ADDR) begin
                        state_nx = ST_IDLE;
                        col_nx   = '0;
                        row_nx   = '0;
                        base_nx  = '0;
                    end else begin
                        sweep_nx = sweep + 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        // clear overrides everything, including a restart mid-sweep
        if (clear_req) begin
            state_nx   = ST_CLEAR;
            fifo_flush = 1'b1;
            fifo_pop   = 1'b0;
            sweep_nx   = '0;
            col_nx     = col;
            row_nx     = row;
            base_nx    = row_base;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            sweep    <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nx;
            col      <= col_nx;
            row      <= row_nx;
            row_base <= base_nx;
            sweep    <= sweep_nx;
            if (clear_req)
                ovf <= 1'b0;
            else if (key_valid && fifo_full)
                ovf <= 1'b1;
        end
    end

    assign ram_addr   = vga_rd_req ? vga_rd_addr : wr_addr;
    assign ram_we     = wr_pend && !vga_rd_req;
    assign ram_wdata  = wr_data;
    assign cursor_col = col;
    assign cursor_row = row;
    assign busy       = (state == ST_CLEAR);

endmodule

// File: doc/kb_text_ctrl.md
# kb_text_ctrl

Controller that sequences writes into the shared character RAM between the PS/2 keyboard decoder and the VGA text renderer. Buffers decoded key characters, maintains the text cursor, interprets control characters and runs full-screen clear sweeps. Arbitrates the single RAM port so that renderer reads always win and writes use idle cycles. Sits between the keyboard unit and the VGA unit in the top level.

## Interface
- COLS, 80, characters per row
- ROWS, 30, character rows
- AW, 12, RAM address width; must satisfy 2^AW ≥ COLS*ROWS
- FIFO_DEPTH, 4, key buffer entries (power of two)
- clk  in  1  system clock; the single clock of the block
- reset  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle pulse; key_char is valid
- key_char  in  8  ASCII code from the keyboard decoder
- clear_req  in  1  one-cycle pulse; clear the screen
- vga_rd_req  in  1  renderer needs the RAM port this cycle
- vga_rd_addr  in  AW  renderer read address
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  5  current row, 0..ROWS-1
- busy  out  1  clear sweep in progress
- ovf  out  1  sticky: a key was dropped

## Operation
- Reset: FIFO empty, state IDLE, cursor (0,0), ram_we 0, ram_wdata 0x00, busy 0, ovf 0. RAM contents are not touched; the top level issues clear_req after reset.
- key_valid pushes key_char into the FIFO.
  - If the FIFO is full, the key is dropped and ovf is set. This applies even when a pop occurs in the same cycle.
- States: IDLE, WRITE, CLEAR.
- IDLE:
  - If the FIFO is non-empty, go to WRITE.
  - If clear_req is seen in any state, go to CLEAR.
- WRITE: process the FIFO head.
  - 0x20..0x7E: write the char at row*COLS+col, advance col. At COLS-1, col wraps to 0 and row increments.
  - 0x08 (backspace): move the cursor back one position (from col 0 to COLS-1 of the previous row), then write 0x20 there. At (0,0), stay at (0,0) and write 0x20 at address 0.
  - 0x0D (enter): col goes to 0, row increments; no RAM write.
  - Any other code: popped and discarded; no write, no cursor change.
  - Row increment from ROWS-1 wraps to 0. There is no scrolling.
  - Pop and cursor update happen in the cycle the write is granted (or immediately for non-writing codes). Then return to IDLE, or stay in WRITE if the FIFO is still non-empty.
- CLEAR: on entry, flush the FIFO, clear ovf, set busy and zero the sweep counter.
  - Write 0x20 to addresses 0..COLS*ROWS-1, one address per granted cycle.
  - After the last address: cursor goes to (0,0), busy drops, state goes to IDLE.
- Arbitration (combinational):
  - ram_addr = vga_rd_req ? vga_rd_addr : write address.
  - ram_we = pending write && !vga_rd_req.
  - A stalled write holds its address, data and state.
- Simultaneous events:
  - clear_req with key_valid in the same cycle: clear wins and the key is discarded.
  - clear_req during CLEAR restarts the sweep at address 0.
  - key_valid during CLEAR, after the entry cycle, is buffered and processed after the sweep.

## Timing
- A key pulsed in cycle N is written no earlier than cycle N+2: push at N, WRITE entered at N+1, ram_we asserted at N+2 if the port is free.
- Cursor outputs update the cycle after the granted write.
- Ungated full clear takes COLS*ROWS cycles (2400 with defaults) plus 1 entry cycle. Each cycle with vga_rd_req high adds one cycle.
- Write latency is unbounded while vga_rd_req stays high; no write is ever lost to a stall.
- Asserting reset mid-sweep or mid-write returns to reset values immediately; a partial sweep is left in RAM.

## Structure
- Shared package kbt_pkg holds:
  - ASCII constants: SPACE 0x20, BS 0x08, CR 0x0D, PRINT_MIN 0x20, PRINT_MAX 0x7E.
  - State encoding: IDLE, WRITE, CLEAR.
  - Default geometry: 80x30.
- One sub-module, kbt_fifo: synchronous FIFO with push, pop, full, empty and dout, parameterised on width and depth, using the same clk and reset.
- Address arithmetic uses a registered row*COLS base updated on each row change, so there is no multiplier in the write path.

## Test plan
- Reset, then clear_req with vga_rd_req=0 → ram_we high for 2400 consecutive cycles, addresses 0..2399, data 0x20; busy falls after the last write; cursor (0,0).
- Keys 'H' (0x48), 'i' (0x69) → writes 0x48 at address 0 and 0x69 at address 1; cursor (2,0).
- Cursor at (79,29), key 'A' → write at address 2399; cursor (0,0). CR at row 29 → cursor row 0 with no write. BS at (0,0) → write 0x20 at address 0; cursor stays (0,0).
- vga_rd_req held high 10 cycles while a key is pending → ram_addr tracks vga_rd_addr and ram_we stays 0; the write is issued on the first cycle vga_rd_req is low.
- Five key pulses on consecutive cycles with vga_rd_req held high → four keys buffered, fifth dropped, ovf=1; a following clear_req clears ovf and flushes the FIFO.
- clear_req and key_valid in the same cycle, then clear_req again mid-sweep → the key never appears in RAM and the sweep restarts at address 0.
